// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction memory request FSM and IF/ID register, with stall and redirect handling
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_src,
    input  logic [31:0] branch_addr,
    input  logic        if_flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
    state_t state, state_nxt;
    logic [31:0] pc, pc_nxt, buf_pc, buf_instr, pend_pc;
    logic redirect, fetch_rdy;
    assign redirect  = !pc_src && if_flush && !stall;
    assign fetch_rdy = (state == FETCH) && imem_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == FETCH) ? (imem_ready ? (stall ? HOLD : FETCH) : (redirect ? DROP : FETCH))
                  : (state == HOLD)  ? (stall ? HOLD : FETCH)
                  : (imem_ready ? FETCH : DROP);
    end
    always_comb begin
        imem_req  = (state != HOLD);
        imem_addr = pc;
    end
    // A word returned while stalled advances pc but parks in the buffer until decode frees up
    always_comb begin
        pc_nxt = fetch_rdy                        ? (redirect ? branch_addr : pc + 32'd4)
               : (state == HOLD && redirect)      ? branch_addr
               : (state == DROP && imem_ready)    ? (redirect ? branch_addr : pend_pc)
               : pc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            buf_pc     <= '0;
            buf_instr  <= '0;
            pend_pc    <= '0;
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            pc <= pc_nxt;
            if (redirect && (state == DROP || (state == FETCH && !imem_ready))) pend_pc <= branch_addr;
            if (fetch_rdy && stall) begin
                buf_pc    <= pc;
                buf_instr <= imem_rdata;
            end
            if (!stall) begin
                if (fetch_rdy && !redirect) begin
                    ifid_pc    <= pc;
                    ifid_instr <= imem_rdata;
                    ifid_valid <= 1'b1;
                end else if (state == HOLD && !redirect) begin
                    ifid_pc    <= buf_pc;
                    ifid_instr <= buf_instr;
                    ifid_valid <= 1'b1;
                end else begin
                    ifid_pc    <= '0;
                    ifid_instr <= NOP_INSTR;
                    ifid_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus random traffic checked against a behavioural fetch model
module tb_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    logic        clk = 0, reset = 0, pc_src = 1, if_flush = 0, stall = 0, imem_ready = 0;
    logic        imem_req, ifid_valid;
    logic [31:0] branch_addr = 0, imem_addr, imem_rdata, ifid_pc, ifid_instr;
    int n_chk = 0, n_pass = 0;
    logic [31:0] m_pc, m_target, m_buf_pc, m_buf_instr, e_pc, e_instr;
    logic        m_held, m_dropping, e_valid;

    fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc_src(pc_src), .branch_addr(branch_addr),
        .if_flush(if_flush), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata = imem_ready ? mem(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all();
        check("imem_req", {31'b0, imem_req}, {31'b0, !m_held});
        check("imem_addr", imem_addr, m_pc);
        check("ifid_valid", {31'b0, ifid_valid}, {31'b0, e_valid});
        check("ifid_instr", ifid_instr, e_instr);
        check("ifid_pc", ifid_pc, e_pc);
    endtask

    task automatic bubble();
        e_valid = 0;
        e_instr = NOP;
        e_pc    = 0;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_target = 0;
        m_held = 0;
        m_dropping = 0;
        bubble();
    endtask

    // One clock of fetch behaviour: a parked word, an outstanding request being dropped, or a normal fetch
    task automatic model_step(input logic r, input logic s, input logic ps, input logic fl, input logic [31:0] ba);
        logic redir;
        redir = !ps && fl && !s;
        if (m_held) begin
            if (!s) begin
                if (redir) begin
                    m_pc = ba;
                    bubble();
                end else begin
                    e_valid = 1;
                    e_pc    = m_buf_pc;
                    e_instr = m_buf_instr;
                end
                m_held = 0;
            end
        end else if (m_dropping) begin
            if (redir) m_target = ba;
            if (!s) bubble();
            if (r) begin
                m_pc = m_target;
                m_dropping = 0;
            end
        end else if (r) begin
            if (redir) begin
                m_pc = ba;
                bubble();
            end else if (s) begin
                m_buf_pc    = m_pc;
                m_buf_instr = mem(m_pc);
                m_held      = 1;
                m_pc        = m_pc + 4;
            end else begin
                e_valid = 1;
                e_pc    = m_pc;
                e_instr = mem(m_pc);
                m_pc    = m_pc + 4;
            end
        end else begin
            if (redir) begin
                m_target   = ba;
                m_dropping = 1;
            end
            if (!s) bubble();
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic ps, input logic fl, input logic [31:0] ba);
        imem_ready  = r;
        stall       = s;
        pc_src      = ps;
        if_flush    = fl;
        branch_addr = ba;
        model_step(r, s, ps, fl, ba);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        check_all();
    endtask

    initial begin
        #2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 1, 0, 0);
            check("seq_pc", ifid_pc, 32'(i * 4));
            check("seq_valid", {31'b0, ifid_valid}, 32'd1);
        end
        do_reset();
        cycle(1, 0, 1, 0, 0);
        cycle(1, 0, 1, 0, 0);
        check("pc_is_8", imem_addr, 32'h8);
        cycle(1, 0, 0, 1, 32'h40);
        check("br_valid", {31'b0, ifid_valid}, 32'd0);
        check("br_nop", ifid_instr, NOP);
        check("br_addr", imem_addr, 32'h40);
        cycle(1, 0, 0, 1, 32'h10);
        cycle(0, 0, 0, 1, 32'h80);
        check("drop_addr0", imem_addr, 32'h10);
        cycle(0, 0, 1, 0, 0);
        check("drop_addr1", imem_addr, 32'h10);
        cycle(0, 0, 1, 0, 0);
        check("drop_addr2", imem_addr, 32'h10);
        cycle(1, 0, 1, 0, 0);
        check("drop_target", imem_addr, 32'h80);
        check("drop_valid", {31'b0, ifid_valid}, 32'd0);
        cycle(1, 0, 0, 1, 32'h20);
        cycle(1, 1, 1, 0, 0);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_valid", {31'b0, ifid_valid}, 32'd0);
        cycle(0, 1, 1, 0, 0);
        check("hold_req2", {31'b0, imem_req}, 32'd0);
        cycle(0, 0, 1, 0, 0);
        check("hold_pc", ifid_pc, 32'h20);
        check("hold_instr", ifid_instr, mem(32'h20));
        check("hold_next", imem_addr, 32'h24);
        cycle(0, 1, 0, 1, 32'h99);
        check("stall_redir", imem_addr, 32'h24);
        cycle(1, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 1, 0, 0);
        check("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        cycle(0, 0, 0, 1, 32'h80);
        cycle(0, 0, 1, 0, 0);
        do_reset();
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", {31'b0, ifid_valid}, 32'd0);
        cycle(1, 0, 1, 0, 0);
        check("rst_first", ifid_pc, RESET_PC);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
